// File: rtl/seqdec_pkg.sv
// Shared constants and FSM encoding for the sequence decomposer control path.
package seqdec_pkg;
  localparam int NUM_DEFAULT = 25000;
  localparam int FS          = 8000;
  localparam int NW          = 24;
  localparam int FW          = 16;
  localparam int KW          = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_WAIT_SYNC
  } state_t;
endpackage

// File: rtl/restoring_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, NW steps per divide.
module restoring_div_seq #(
  parameter int NW = seqdec_pkg::NW,
  parameter int FW = seqdec_pkg::FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [FW-1:0] divisor_i,
  output logic          done_o,
  output logic [NW-1:0] quo_o,
  output logic [FW-1:0] rem_o
);
  localparam int CW = $clog2(NW + 1);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [NW-1:0] quo_q, quo_d;
  logic [FW-1:0] rem_q, rem_d, div_q;
  logic [FW:0]   sh, diff;
  logic          ge;

  always_comb begin
    sh    = {rem_q, quo_q[NW-1]};
    diff  = sh - {1'b0, div_q};
    ge    = (sh >= {1'b0, div_q});
    rem_d = ge ? diff[FW-1:0] : sh[FW-1:0];
    quo_d = {quo_q[NW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= CW'(NW);
    end else if (run_q) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      div_q <= divisor_i;
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  // done marks the cycle whose edge performs the last step, so results are final one cycle later
  assign done_o = run_q && (cnt_q == CW'(1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/decim_ctrl.sv
// Turns measured reference frequency into decimation factor k, committed on frame boundaries.
module decim_ctrl #(
  parameter int NUM   = seqdec_pkg::NUM_DEFAULT,
  parameter int NW    = seqdec_pkg::NW,
  parameter int FW    = seqdec_pkg::FW,
  parameter int KW    = seqdec_pkg::KW,
  parameter int K_MIN = 1,
  parameter int K_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] freq_in,
  input  logic          freq_valid,
  input  logic          frame_sync,
  output logic [KW-1:0] k,
  output logic          k_valid,
  output logic          busy,
  output logic          ovr
);
  import seqdec_pkg::*;

  state_t        state_q;
  logic [FW-1:0] f_q, qf_q, div_divisor;
  logic          qv_q, k_valid_q, ovr_q;
  logic [KW-1:0] k_q, k_pend_q, k_pend_d;
  logic          q_store, q_take, div_start, div_done;
  logic [NW-1:0] div_quo;
  logic [FW-1:0] div_rem;

  function automatic logic [NW:0] round_q(input logic [NW-1:0] q, input logic [FW-1:0] r,
                                          input logic [FW-1:0] f);
    return {1'b0, q} + {{NW{1'b0}}, (r > (f >> 1))};
  endfunction

  function automatic logic [KW-1:0] clamp_k(input logic [NW:0] kp);
    if (kp < (NW+1)'(K_MIN)) return KW'(K_MIN);
    if (kp > (NW+1)'(K_MAX)) return KW'(K_MAX);
    return kp[KW-1:0];
  endfunction

  // A queued frequency is consumed in WAIT_SYNC whether or not the commit happens
  always_comb begin
    q_store     = freq_valid && (state_q != S_IDLE);
    q_take      = (state_q == S_WAIT_SYNC) && qv_q;
    div_start   = 1'b0;
    div_divisor = freq_in;
    if (state_q == S_IDLE && freq_valid && freq_in != '0) div_start = 1'b1;
    if (q_take) begin
      div_divisor = qf_q;
      div_start   = (qf_q != '0);
    end
    k_pend_d = (f_q == '0) ? clamp_k((NW+1)'(1)) : clamp_k(round_q(div_quo, div_rem, f_q));
  end

  restoring_div_seq #(.NW(NW), .FW(FW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(NW'(NUM)),
    .divisor_i (div_divisor),
    .done_o    (div_done),
    .quo_o     (div_quo),
    .rem_o     (div_rem)
  );

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && freq_valid) f_q <= freq_in;
    else if (q_take)                     f_q <= qf_q;
    if (q_store)                         qf_q <= freq_in;
    if (state_q == S_ROUND)              k_pend_q <= k_pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= KW'(1);
      k_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
      qv_q      <= 1'b0;
    end else begin
      k_valid_q <= 1'b0;
      if (q_store)     qv_q <= 1'b1;
      else if (q_take) qv_q <= 1'b0;
      if (q_store && qv_q && !q_take) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE:      if (freq_valid) state_q <= (freq_in == '0) ? S_ROUND : S_DIV;
        S_DIV:       if (div_done) state_q <= S_ROUND;
        S_ROUND:     state_q <= S_WAIT_SYNC;
        S_WAIT_SYNC: begin
          if (frame_sync) begin
            k_q       <= k_pend_q;
            k_valid_q <= 1'b1;
          end
          if (q_take)          state_q <= (qf_q == '0) ? S_ROUND : S_DIV;
          else if (frame_sync) state_q <= S_IDLE;
        end
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign k       = k_q;
  assign k_valid = k_valid_q;
  assign busy    = (state_q != S_IDLE);
  assign ovr     = ovr_q;
endmodule

// File: tb/tb_decim_ctrl.sv
// Self-checking bench for decim_ctrl: directed scenarios plus randomized frequencies vs. arithmetic model.
module tb_decim_ctrl;
  localparam int NUM = 25000;
  localparam int NW  = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] freq_in;
  logic        freq_valid;
  logic        frame_sync;
  logic [7:0]  k;
  logic        k_valid;
  logic        busy;
  logic        ovr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decim_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .freq_in   (freq_in),
    .freq_valid(freq_valid),
    .frame_sync(frame_sync),
    .k         (k),
    .k_valid   (k_valid),
    .busy      (busy),
    .ovr       (ovr)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_k(input int f);
    int q, r, kp;
    if (f == 0) return 1;
    q  = NUM / f;
    r  = NUM % f;
    kp = q + ((r > f / 2) ? 1 : 0);
    if (kp < 1)   kp = 1;
    if (kp > 255) kp = 255;
    return kp;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int f);
    freq_in    = 16'(f);
    freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
  endtask

  task automatic tick_n(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (k_valid) pulses++;
    end
  endtask

  task automatic wait_kv(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (k_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc, p, f1, f2, d, prev;
    rst        = 1'b1;
    freq_in    = '0;
    freq_valid = 1'b0;
    frame_sync = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_k", k, 1);
    check_eq("rst_kvalid", k_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovr", ovr, 0);

    // 5000 with frame_sync at cycle ~30
    send(5000);
    tick_n(28, p);
    check_eq("f5000_nopulse", p, 0);
    check_eq("f5000_kstable", k, 1);
    check_eq("f5000_busy", busy, 1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check_eq("f5000_kvalid", k_valid, 1);
    check_eq("f5000_k", k, 5);
    check_eq("f5000_idle", busy, 0);
    tick_n(5, p);
    check_eq("f5000_single", p, 0);

    // frame_sync held high: earliest commit latency, no double commit
    frame_sync = 1'b1;
    send(7000);
    wait_kv(60, cyc);
    check_eq("f7000_lat", cyc, NW + 2);
    check_eq("f7000_k", k, 4);
    tick_n(5, p);
    check_eq("held_sync_nodouble", p, 0);
    send(6000);
    wait_kv(60, cyc);
    check_eq("f6000_lat", cyc, NW + 2);
    check_eq("f6000_k", k, 4);
    send(0);
    wait_kv(60, cyc);
    check_eq("f0_lat", cyc, 2);
    check_eq("f0_k", k, 1);
    send(50);
    wait_kv(60, cyc);
    check_eq("f50_k", k, 255);

    // three strobes while dividing: overwrite sets ovr, newest queued value wins
    send(5000);
    tick_n(3, p);
    send(6250);
    tick_n(2, p);
    send(4000);
    check_eq("ovr_set", ovr, 1);
    wait_kv(60, cyc);
    check_eq("ovr_first_lat", cyc, 19);
    check_eq("ovr_first_k", k, 5);
    wait_kv(60, cyc);
    check_eq("ovr_second_lat", cyc, NW + 2);
    check_eq("ovr_second_k", k, 6);
    check_eq("ovr_sticky", ovr, 1);
    tick();
    check_eq("ovr_idle", busy, 0);

    // reset in the middle of a division
    frame_sync = 1'b0;
    send(5000);
    tick_n(10, p);
    rst = 1'b1;
    #1;
    check_eq("midrst_k", k, 1);
    check_eq("midrst_kvalid", k_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ovr", ovr, 0);
    tick();
    rst = 1'b0;
    frame_sync = 1'b1;
    send(5000);
    wait_kv(60, cyc);
    check_eq("postrst_lat", cyc, NW + 2);
    check_eq("postrst_k", k, 5);

    // stale pending value replaced by a newer measurement
    send(0);
    wait_kv(60, cyc);
    check_eq("stale_pre_k", k, 1);
    frame_sync = 1'b0;
    send(5000);
    tick_n(40, p);
    check_eq("stale_nopulse", p, 0);
    check_eq("stale_kstable", k, 1);
    check_eq("stale_busy", busy, 1);
    send(2500);
    tick();
    frame_sync = 1'b1;
    wait_kv(60, cyc);
    frame_sync = 1'b0;
    check_eq("stale_lat", cyc, NW + 2);
    check_eq("stale_k", k, 10);

    // randomized frequencies, single or overwritten-before-commit
    prev = 10;
    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, 9);
      if (d == 0)      f1 = 0;
      else if (d == 1) f1 = $urandom_range(1, 200);
      else             f1 = $urandom_range(1, 65535);
      if ($urandom_range(0, 2) == 0) begin
        f2 = $urandom_range(1, 65535);
        send(f1);
        tick_n($urandom_range(1, 20), p);
        send(f2);
        tick_n(60, p);
        check_eq("rnd2_nopulse", p, 0);
        check_eq("rnd2_kstable", k, prev);
        frame_sync = 1'b1;
        wait_kv(60, cyc);
        frame_sync = 1'b0;
        check_eq("rnd2_seen", (cyc > 0) ? 1 : 0, 1);
        check_eq("rnd2_k", k, ref_k(f2));
        prev = ref_k(f2);
      end else begin
        send(f1);
        tick_n($urandom_range(0, 40), p);
        check_eq("rnd_nopulse", p, 0);
        check_eq("rnd_kstable", k, prev);
        frame_sync = 1'b1;
        wait_kv(60, cyc);
        frame_sync = 1'b0;
        check_eq("rnd_seen", (cyc > 0) ? 1 : 0, 1);
        check_eq("rnd_k", k, ref_k(f1));
        prev = ref_k(f1);
      end
    end
    check_eq("final_ovr", ovr, 0);
    check_eq("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decim_ctrl.md
# decim_ctrl

Sequential controller that turns the measured reference frequency into the decimation factor `k` for the decimating clock generator, FIR filters and DZCPD blocks of the sequence decomposer. It replaces the combinational 24-bit divide with a one-bit-per-cycle restoring divider, then rounds and clamps the result. The new `k` is committed only on a frame boundary, so every downstream analysis window runs with a single consistent `k`.

## Interface
- `NUM`, 25000, dividend (Fs·100/N with Fs = 8000)
- `NW`, 24, divider datapath width
- `FW`, 16, frequency width (units of 0.01 Hz)
- `KW`, 8, width of `k`
- `K_MIN`, 1, lower clamp for `k`
- `K_MAX`, 255, upper clamp for `k`

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `freq_in` in FW: measured reference frequency
- `freq_valid` in 1: one-cycle strobe; `freq_in` is valid in the same cycle
- `frame_sync` in 1: window-boundary strobe; a commit can happen only when it is high
- `k` out KW: committed decimation factor
- `k_valid` out 1: one-cycle pulse in the cycle after `k` changes
- `busy` out 1: high when the FSM is not in IDLE
- `ovr` out 1: sticky flag; a queued frequency was overwritten before it was used

## Operation
- FSM states: IDLE, DIV, ROUND, WAIT_SYNC.
- **IDLE**
  - On `freq_valid`, latch `freq_in` as `f`.
  - If `f == 0`, go to ROUND with the result forced to 1.
  - Otherwise load the remainder with 0, the quotient with `NUM` and the bit counter with `NW`, then go to DIV.
- **DIV** (restoring division, one quotient bit per cycle)
  - Shift {rem, quo} left by 1.
  - If rem ≥ f: rem −= f and set quotient bit 0.
  - After exactly `NW` cycles, go to ROUND.
- **ROUND**
  - `kp = q + (r > (f>>1))`, computed on a width of NW+1 bits.
  - Clamp `kp` to [K_MIN, K_MAX], store it as `k_pend`, go to WAIT_SYNC.
- **WAIT_SYNC**
  - On `frame_sync`: `k <= k_pend`, pulse `k_valid`. Then go to IDLE, or go straight to DIV/ROUND if a queued frequency exists.
  - If a queued frequency exists and `frame_sync` is low: drop the stale `k_pend` and restart from the queued value, so the newest measurement wins.
- **Queue** (one-deep)
  - `freq_valid` in any state other than IDLE stores `freq_in` in the queue and sets the queue-valid bit.
  - If the queue is already valid, overwrite it and set `ovr`.
- **k_valid pulse**
  - `k_valid` pulses on every commit, including when `k_pend` equals the current `k`.
- **Simultaneous events**
  - `frame_sync` and a new `freq_valid` in the same WAIT_SYNC cycle: the commit happens, and the new value is queued.
- **Reset**
  - Values on reset: `k` = 1, `k_valid` = 0, `busy` = 0, `ovr` = 0, queue empty, state IDLE.
  - Reset in the middle of a division discards all intermediate state.

## Timing
- `freq_valid` sampled at edge 0 (non-zero f) → DIV on edges 1..NW → ROUND at edge NW+1 → WAIT_SYNC from edge NW+2.
- The earliest `k` update is at edge NW+2, when `frame_sync` is high in the first WAIT_SYNC cycle. `k_valid` is high for one cycle after that edge.
- With `f == 0`: ROUND at edge 1, earliest commit at edge 2.
- `busy` is high from the edge after acceptance until the commit edge.
- `frame_sync` held high continuously: a commit happens at the first WAIT_SYNC cycle; no double commit.
- `k` is stable at every time except the commit edge.

## Structure
- A shared package `seqdec_pkg` holds:
  - state enum
  - `NUM_DEFAULT` = 25000, `FS` = 8000
  - the width constants `NW`, `FW`, `KW`
- One sub-module, `restoring_div_seq`:
  - handshake: start/done
  - operand widths: NW-bit dividend, FW-bit divisor
  - outputs: quotient and remainder
- `decim_ctrl` owns the FSM, rounding, clamping, the queue and the commit logic.

## Test plan
- `freq_in` = 5000, `frame_sync` high at cycle 30 → `k` = 5, one `k_valid` pulse, `busy` low afterwards.
- `freq_in` = 7000 (q = 3, r = 4000 > 3500) → `k` = 4; `freq_in` = 6000 (q = 4, r = 1000) → `k` = 4.
- `freq_in` = 0 → `k` = 1 committed on the first `frame_sync` at cycle ≥ 2; `freq_in` = 50 (q = 500) → `k` = 255 (clamp).
- Three `freq_valid` strobes (5000, 6250, 4000) during one DIV → `ovr` = 1. Commits: `k` = 5, then `k` = 6 (25000/4000 = 6.25, rounds down; the 6250 strobe was overwritten).
- `rst` asserted at DIV cycle 10 → all outputs return to reset values immediately; a following 5000 strobe yields `k` = 5 normally.
- WAIT_SYNC held with no `frame_sync` while a new strobe of 2500 arrives → `k_pend` is recomputed; the next `frame_sync` commits `k` = 10 only, never 5.
